// File: rtl/iter_mult_responder_if.sv
// Valid/ready stream bundle shared by the multiplier request and response sides.
// The sink modport drives only rdy; the source drives everything else.
interface if_axi_stream #(
  parameter int DAT_BITS = 8,
  parameter int CTL_BITS = 8,
  parameter int MOD_BITS = 8
);
  logic                val;
  logic                rdy;
  logic                sop;
  logic                eop;
  logic                err;
  logic [DAT_BITS-1:0] dat;
  logic [CTL_BITS-1:0] ctl;
  logic [MOD_BITS-1:0] mod;

  modport source (output val, sop, eop, err, dat, ctl, mod, input rdy);
  modport sink   (input val, sop, eop, err, dat, ctl, mod, output rdy);
endinterface

// File: rtl/iter_mult_responder.sv
// Digit-serial unsigned multiplier: one MUL_BITS digit of b per cycle, accumulated into a
// 2*DAT_BITS sum and returned as a single-beat response with ctl echoed.
module iter_mult_responder #(
  parameter int DAT_BITS = 381,
  parameter int MUL_BITS = 64,
  parameter int CTL_BITS = 8
) (
  input logic          i_clk,
  input logic          i_rst,
  if_axi_stream.sink   i_mul_if,
  if_axi_stream.source o_mul_if
);
  localparam int NUM_DIG  = (DAT_BITS + MUL_BITS - 1) / MUL_BITS;
  localparam int PAD_BITS = NUM_DIG * MUL_BITS;
  localparam int ACC_BITS = 2 * DAT_BITS;
  localparam int PP_BITS  = DAT_BITS + MUL_BITS;
  localparam int CNT_BITS = (NUM_DIG > 1) ? $clog2(NUM_DIG) : 1;
  localparam logic [CNT_BITS-1:0] LAST_DIG = CNT_BITS'(NUM_DIG - 1);

  typedef enum logic [1:0] {StIdle, StMul, StOut} state_e;

  state_e              r_state;
  logic [DAT_BITS-1:0] r_a;
  logic [PAD_BITS-1:0] r_b;
  logic [CTL_BITS-1:0] r_ctl;
  logic [ACC_BITS-1:0] r_acc;
  logic [CNT_BITS-1:0] r_cnt;
  logic [ACC_BITS-1:0] r_out_dat;
  logic [CTL_BITS-1:0] r_out_ctl;
  logic                r_out_val;
  logic                r_out_sop;

  logic [MUL_BITS-1:0] w_dig;
  logic [PP_BITS-1:0]  w_pp;
  logic [ACC_BITS-1:0] w_pp_sh;
  logic [ACC_BITS-1:0] w_sum;
  logic                w_unused_sink;

  assign w_dig   = r_b[r_cnt * MUL_BITS +: MUL_BITS];
  assign w_pp    = PP_BITS'(r_a) * PP_BITS'(w_dig);
  // PP_BITS <= ACC_BITS because MUL_BITS <= DAT_BITS; shifted-out bits are always zero.
  assign w_pp_sh = ACC_BITS'(w_pp) << (r_cnt * MUL_BITS);
  assign w_sum   = r_acc + w_pp_sh;

  assign w_unused_sink = ^{i_mul_if.sop, i_mul_if.eop, i_mul_if.err, i_mul_if.mod};

  assign i_mul_if.rdy = (r_state == StIdle) && !i_rst;

  assign o_mul_if.val = r_out_val;
  assign o_mul_if.sop = r_out_sop;
  assign o_mul_if.eop = r_out_sop;
  assign o_mul_if.err = 1'b0;
  assign o_mul_if.mod = '0;
  assign o_mul_if.dat = r_out_dat;
  assign o_mul_if.ctl = r_out_ctl;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state   <= StIdle;
      r_a       <= '0;
      r_b       <= '0;
      r_ctl     <= '0;
      r_acc     <= '0;
      r_cnt     <= '0;
      r_out_dat <= '0;
      r_out_ctl <= '0;
      r_out_val <= 1'b0;
      r_out_sop <= 1'b0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (i_mul_if.val) begin
            r_a     <= i_mul_if.dat[0 +: DAT_BITS];
            r_b     <= PAD_BITS'(i_mul_if.dat[DAT_BITS +: DAT_BITS]);
            r_ctl   <= i_mul_if.ctl;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_state <= StMul;
          end
        end
        StMul: begin
          r_acc <= w_sum;
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == LAST_DIG) begin
            r_out_dat <= w_sum;
            r_out_ctl <= r_ctl;
            r_out_val <= 1'b1;
            r_out_sop <= 1'b1;
            r_state   <= StOut;
          end
        end
        StOut: begin
          if (o_mul_if.rdy) begin
            r_out_val <= 1'b0;
            r_out_sop <= 1'b0;
            r_state   <= StIdle;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end
endmodule

// File: tb/tb_iter_mult_responder.sv
// Randomized and directed checks of iter_mult_responder in three configurations
// (16/4, 18/8 and 8/8) against a plain-arithmetic product model.
module tb_iter_mult_responder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  if_axi_stream #(.DAT_BITS(32), .CTL_BITS(8)) a_req ();
  if_axi_stream #(.DAT_BITS(32), .CTL_BITS(8)) a_rsp ();
  if_axi_stream #(.DAT_BITS(36), .CTL_BITS(8)) b_req ();
  if_axi_stream #(.DAT_BITS(36), .CTL_BITS(8)) b_rsp ();
  if_axi_stream #(.DAT_BITS(16), .CTL_BITS(8)) c_req ();
  if_axi_stream #(.DAT_BITS(16), .CTL_BITS(8)) c_rsp ();

  iter_mult_responder #(.DAT_BITS(16), .MUL_BITS(4), .CTL_BITS(8)) u_dut_a (
    .i_clk(clk), .i_rst(rst), .i_mul_if(a_req), .o_mul_if(a_rsp)
  );
  iter_mult_responder #(.DAT_BITS(18), .MUL_BITS(8), .CTL_BITS(8)) u_dut_b (
    .i_clk(clk), .i_rst(rst), .i_mul_if(b_req), .o_mul_if(b_rsp)
  );
  iter_mult_responder #(.DAT_BITS(8), .MUL_BITS(8), .CTL_BITS(8)) u_dut_c (
    .i_clk(clk), .i_rst(rst), .i_mul_if(c_req), .o_mul_if(c_rsp)
  );

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  logic [15:0] qa[$];
  logic [15:0] qb[$];
  logic [7:0]  qc[$];
  logic [39:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic [63:0] a, input logic [63:0] b);
    return a * b;
  endfunction

  task automatic push_req(input logic [15:0] a, input logic [15:0] b, input logic [7:0] c);
    qa.push_back(a);
    qb.push_back(b);
    qc.push_back(c);
  endtask

  // Drains qa/qb/qc through DUT A with random val/rdy duty, scoreboarding responses.
  task automatic run_stream(input int p_val, input int p_rdy, input bit chk_tp);
    int          n;
    int          sent;
    int          got;
    int          fire_cyc;
    int          last_fire;
    bit          pend;
    bit          prev_oval;
    logic [39:0] e;
    logic [63:0] p;
    n = qa.size(); sent = 0; got = 0; fire_cyc = 0; last_fire = -1; pend = 0; prev_oval = 0;
    for (int t = 0; t < 20000 && got < n; t++) begin
      @(negedge clk);
      if (a_rsp.val && !prev_oval) check("latency", 64'(cyc - fire_cyc - 1), 64'd4);
      prev_oval = a_rsp.val;
      a_rsp.rdy = ($urandom_range(99) < p_rdy);
      if (a_rsp.val && a_rsp.rdy) begin
        if (exp_q.size() == 0) begin
          check("extra_beat", 64'd1, 64'd0);
        end else begin
          e = exp_q.pop_front();
          check("dat", 64'(a_rsp.dat), 64'(e[31:0]));
          check("ctl", 64'(a_rsp.ctl), 64'(e[39:32]));
          check("sop_eop_err_mod", 64'({a_rsp.sop, a_rsp.eop, a_rsp.err, a_rsp.mod}),
                64'({1'b1, 1'b1, 1'b0, 8'h00}));
        end
        got++;
      end
      if (!pend) begin
        a_req.val = 1'b0;
        if (sent < n && $urandom_range(99) < p_val) begin
          a_req.val = 1'b1;
          a_req.dat = {qb[sent], qa[sent]};
          a_req.ctl = qc[sent];
          pend = 1;
        end
      end
      // rdy depends only on state, so this predicts the handshake at the coming edge.
      if (pend && a_req.rdy) begin
        p = model(64'(qa[sent]), 64'(qb[sent]));
        exp_q.push_back({qc[sent], p[31:0]});
        if (chk_tp && last_fire >= 0) check("throughput", 64'(cyc - last_fire), 64'd6);
        last_fire = cyc;
        fire_cyc  = cyc;
        sent++;
        pend = 0;
      end
    end
    check("stream_drain", 64'(got), 64'(n));
    qa.delete(); qb.delete(); qc.delete();
  endtask

  task automatic txn_b(input logic [17:0] a, input logic [17:0] b);
    int fire_cyc;
    @(negedge clk);
    b_req.val = 1'b1; b_req.dat = {b, a}; b_req.ctl = a[7:0];
    check("b_rdy", 64'(b_req.rdy), 64'd1);
    fire_cyc = cyc;
    @(negedge clk);
    b_req.val = 1'b0;
    for (int i = 0; i < 20 && !b_rsp.val; i++) @(negedge clk);
    check("b_lat", 64'(cyc - fire_cyc - 1), 64'd3);
    check("b_dat", 64'(b_rsp.dat), model(64'(a), 64'(b)));
    check("b_ctl", 64'(b_rsp.ctl), 64'(a[7:0]));
  endtask

  task automatic txn_c(input logic [7:0] a, input logic [7:0] b);
    int fire_cyc;
    @(negedge clk);
    c_req.val = 1'b1; c_req.dat = {b, a}; c_req.ctl = b;
    check("c_rdy", 64'(c_req.rdy), 64'd1);
    fire_cyc = cyc;
    @(negedge clk);
    c_req.val = 1'b0;
    for (int i = 0; i < 20 && !c_rsp.val; i++) @(negedge clk);
    check("c_lat", 64'(cyc - fire_cyc - 1), 64'd1);
    check("c_dat", 64'(c_rsp.dat), model(64'(a), 64'(b)));
    check("c_ctl", 64'(c_rsp.ctl), 64'(b));
  endtask

  initial begin
    int          bad;
    logic [63:0] bp_exp;
    a_req.val = 0; a_req.dat = '0; a_req.ctl = '0;
    a_req.sop = 0; a_req.eop = 0; a_req.err = 0; a_req.mod = '0;
    b_req.val = 0; b_req.dat = '0; b_req.ctl = '0;
    b_req.sop = 0; b_req.eop = 0; b_req.err = 0; b_req.mod = '0;
    c_req.val = 0; c_req.dat = '0; c_req.ctl = '0;
    c_req.sop = 0; c_req.eop = 0; c_req.err = 0; c_req.mod = '0;
    a_rsp.rdy = 1; b_rsp.rdy = 1; c_rsp.rdy = 1;

    repeat (3) @(negedge clk);
    check("rst_val", 64'(a_rsp.val), 64'd0);
    check("rst_outs", 64'({a_rsp.sop, a_rsp.eop, a_rsp.err, a_rsp.mod, a_rsp.ctl, a_rsp.dat}),
          64'd0);
    check("rst_rdy", 64'(a_req.rdy), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_rdy", 64'(a_req.rdy), 64'd1);

    push_req(16'hFFFF, 16'hFFFF, 8'h5A);
    run_stream(100, 100, 0);

    for (int i = 0; i < 6; i++) push_req(16'($urandom), 16'($urandom), 8'($urandom));
    run_stream(100, 100, 1);

    for (int i = 0; i < 100; i++) push_req(16'($urandom), 16'($urandom), 8'($urandom));
    push_req(16'h0000, 16'hBEEF, 8'h01);
    push_req(16'hBEEF, 16'h0000, 8'h02);
    run_stream(60, 60, 0);

    // Backpressure: response must hold for 10 cycles with request side stalled.
    @(negedge clk);
    a_rsp.rdy = 0; a_req.val = 1; a_req.dat = {16'h5678, 16'h1234}; a_req.ctl = 8'h3C;
    bp_exp = model(64'h1234, 64'h5678);
    @(negedge clk);
    a_req.val = 0;
    for (int i = 0; i < 20 && !a_rsp.val; i++) @(negedge clk);
    check("bp_val", 64'(a_rsp.val), 64'd1);
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (a_rsp.dat !== bp_exp[31:0] || a_rsp.val !== 1'b1 || a_req.rdy !== 1'b0) bad++;
    end
    check("bp_hold", 64'(bad), 64'd0);
    check("bp_dat", 64'(a_rsp.dat), bp_exp);
    a_rsp.rdy = 1;
    @(negedge clk);
    check("bp_one_beat", 64'(a_rsp.val), 64'd0);
    check("bp_idle_rdy", 64'(a_req.rdy), 64'd1);

    // Reset two cycles into the multiply.
    a_req.val = 1; a_req.dat = {16'h0101, 16'h0202}; a_req.ctl = 8'h11;
    @(negedge clk);
    a_req.val = 0;
    repeat (2) @(negedge clk);
    #1 rst = 1'b1;
    #1 check("rst_mul_val", 64'(a_rsp.val), 64'd0);
    check("rst_mul_rdy", 64'(a_req.rdy), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // Reset while holding a response.
    a_rsp.rdy = 0;
    a_req.val = 1; a_req.dat = {16'h0033, 16'h0044}; a_req.ctl = 8'h22;
    @(negedge clk);
    a_req.val = 0;
    for (int i = 0; i < 20 && !a_rsp.val; i++) @(negedge clk);
    check("pre_rst_out_val", 64'(a_rsp.val), 64'd1);
    #2 rst = 1'b1;
    #1 check("rst_out_val", 64'(a_rsp.val), 64'd0);
    check("rst_out_outs", 64'({a_rsp.sop, a_rsp.eop, a_rsp.ctl, a_rsp.dat}), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    a_rsp.rdy = 1;
    bad = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (a_rsp.val !== 1'b0) bad++;
    end
    check("no_resp_after_rst", 64'(bad), 64'd0);
    push_req(16'd3, 16'd5, 8'h77);
    run_stream(100, 100, 0);

    txn_b(18'h3FFFF, 18'h20001);
    txn_b(18'h00000, 18'h2ABCD);
    txn_b(18'h1F0F0, 18'h00000);
    for (int i = 0; i < 4; i++) txn_b(18'($urandom), 18'($urandom));

    txn_c(8'hFF, 8'h02);
    for (int i = 0; i < 4; i++) txn_c(8'($urandom), 8'($urandom));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
